// File: rtl/adder64_pkg.sv
// Shared types and helpers for the adder64_sched scheduler slice.
package adder64_pkg;

   localparam int WORD_W  = 64;
   localparam int MAX_REQ = 8;
   localparam int PICK_W  = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // First set bit of valid at or after ptr, wrapping. Requester counts below
   // MAX_REQ leave the upper valid bits at zero, so the wrap at MAX_REQ gives the
   // same winner as a wrap at the real requester count.
   function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PICK_W-1:0]  ptr);
      logic [PICK_W-1:0] idx;
      rr_pick = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         idx = ptr + PICK_W'(k);
         if (valid[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/add64_core.sv
// Combinational 64-bit adder with carry-in and carry-out: {cout,sum} = a + b + cin.
module add64_core
   import adder64_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/adder64_sched.sv
// Round-robin scheduler sharing one 64-bit adder among NUM_REQ requesters.
// Define ADD64_CHAIN_EN to build the LOCKED state for carry-chained multi-word adds.
module adder64_sched
   import adder64_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 3
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*WORD_W-1:0] req_a,
   input  logic [NUM_REQ*WORD_W-1:0] req_b,
   input  logic [NUM_REQ-1:0]        req_cin,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [WORD_W-1:0]         resp_sum,
   output logic                      resp_cout,
   output logic [ID_W-1:0]           resp_id
);

   state_t              state;
   state_t              state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     ptr_nxt;
   logic [ID_W-1:0]     grant_id;
   logic [NUM_REQ-1:0]  valid_eff;
   logic                can_load;
   logic                xfer;
   logic                grant_last;
   logic [WORD_W-1:0]   op_a;
   logic [WORD_W-1:0]   op_b;
   logic                op_cin;
   logic [WORD_W-1:0]   add_sum;
   logic                add_cout;

   assign can_load = !resp_valid || resp_ready;

`ifdef ADD64_CHAIN_EN
   logic [ID_W-1:0] owner;

   // While locked, only the chain owner is visible to the arbiter.
   always_comb begin
      valid_eff = req_valid;
      if (state == LOCKED) valid_eff = req_valid & (NUM_REQ'(1) << owner);
   end
`else
   logic unused_last;

   assign unused_last = ^req_last;
   assign valid_eff   = req_valid;
`endif

   assign grant_id = ID_W'(rr_pick(MAX_REQ'(valid_eff), PICK_W'(rr_ptr)));
   assign xfer     = rst_n && can_load && (|valid_eff);
   assign ptr_nxt  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // NOTE: every always_comb output gets a default before any branch, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      op_a       = '0;
      op_b       = '0;
      op_cin     = 1'b0;
      grant_last = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            op_a   = req_a[i*WORD_W +: WORD_W];
            op_b   = req_b[i*WORD_W +: WORD_W];
            op_cin = req_cin[i];
`ifdef ADD64_CHAIN_EN
            grant_last = req_last[i];
`endif
         end
      end
`ifdef ADD64_CHAIN_EN
      // Later words of a chain take the carry left in the result register.
      if (state == LOCKED) op_cin = resp_cout;
`endif
   end

   add64_core u_core (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

`ifdef ADD64_CHAIN_EN
   // NOTE: clocked state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= '0;
      end else begin
         state <= state_nxt;
         if (xfer && state == IDLE) owner <= grant_id;
      end
   end

   always_comb begin
      state_nxt = state;
      if (xfer) state_nxt = grant_last ? IDLE : LOCKED;
   end
`else
   assign state = IDLE;

   always_comb begin
      state_nxt = state;
   end
`endif

   // A reset-low requester never sees ready, even though the empty slot can load.
   always_comb begin
      req_ready = '0;
      if (xfer) req_ready = NUM_REQ'(1) << grant_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_sum   <= '0;
         resp_cout  <= 1'b0;
         resp_id    <= '0;
         rr_ptr     <= '0;
      end else begin
         if (xfer) begin
            resp_valid <= 1'b1;
            resp_sum   <= add_sum;
            resp_cout  <= add_cout;
            resp_id    <= grant_id;
         end else if (resp_ready) begin
            resp_valid <= 1'b0;
         end
         // The pointer only moves once a transfer leaves the arbiter unlocked.
         if (xfer && state_nxt == IDLE) rr_ptr <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_adder64_sched.sv
// Directed self-checking bench for adder64_sched (both with and without ADD64_CHAIN_EN).
module tb_adder64_sched;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 3;

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*64-1:0] req_a;
   logic [NUM_REQ*64-1:0] req_b;
   logic [NUM_REQ-1:0]    req_cin;
   logic [NUM_REQ-1:0]    req_last;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [63:0]           resp_sum;
   logic                  resp_cout;
   logic [ID_W-1:0]       resp_id;

   int n_cmp = 0;
   int n_bad = 0;

   adder64_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cin    (req_cin),
      .req_last   (req_last),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_id    (resp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic last);
      req_a[i*64 +: 64] = a;
      req_b[i*64 +: 64] = b;
      req_cin[i]        = cin;
      req_last[i]       = last;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_cin    = '0;
      req_last   = '1;
      resp_ready = 1'b0;

      // Reset state, with requests already pending.
      #1;
      req_valid = '1;
      #1;
      check("rst_ready", req_ready, 4'b0000);
      check("rst_valid", resp_valid, 1'b0);
      check("rst_sum", resp_sum, 64'h0);
      check("rst_cout", resp_cout, 1'b0);
      check("rst_id", resp_id, 3'd0);
      step();
      step();
      rst_n      = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b1;

      // Single request: all-ones + 1 wraps to zero with carry out.
      set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
      req_valid = 4'b0001;
      #1;
      check("single_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      check("single_valid", resp_valid, 1'b1);
      check("single_sum", resp_sum, 64'h0);
      check("single_cout", resp_cout, 1'b1);
      check("single_id", resp_id, 3'd0);

      // Carry-in contributes; no carry out.
      set_req(2, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b1);
      req_valid = 4'b0100;
      #1;
      check("cin_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      check("cin_sum", resp_sum, 64'h1234_5678_9ABC_DF01);
      check("cin_cout", resp_cout, 1'b0);
      check("cin_id", resp_id, 3'd2);

      // Top-bit overflow with carry-in.
      set_req(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
      req_valid = 4'b1000;
      #1;
      check("ovf_ready", req_ready, 4'b1000);
      step();
      req_valid = '0;
      check("ovf_sum", resp_sum, 64'h1);
      check("ovf_cout", resp_cout, 1'b1);
      check("ovf_id", resp_id, 3'd3);

      // Fairness: everyone valid, pointer at 0; sum of requester i is 0x101*(i+1).
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, 64'((i + 1) << 8), 64'(i + 1), 1'b0, 1'b1);
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("fair_ready", req_ready, 64'(1) << order[k]);
         step();
         check("fair_valid", resp_valid, 1'b1);
         check("fair_id", resp_id, 64'(order[k]));
         check("fair_sum", resp_sum, 64'(32'h101 * (order[k] + 1)));
      end

      // Backpressure: slot holds requester 0's result while req1 waits.
      req_valid  = 4'b0010;
      resp_ready = 1'b0;
      set_req(1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1);
      #1;
      for (int k = 0; k < 5; k++) begin
         check("bp_ready", req_ready, 4'b0000);
         check("bp_valid", resp_valid, 1'b1);
         check("bp_id", resp_id, 3'd0);
         check("bp_sum", resp_sum, 64'h101);
         step();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_release_ready", req_ready, 4'b0010);
      step();
      req_valid = '0;
      check("bp_load_valid", resp_valid, 1'b1);
      check("bp_load_id", resp_id, 3'd1);
      check("bp_load_sum", resp_sum, 64'h0);
      check("bp_load_cout", resp_cout, 1'b1);
      step();
      check("bp_drain_valid", resp_valid, 1'b0);

`ifdef ADD64_CHAIN_EN
      // Chain on requester 2 while 0 and 3 compete; pointer sits at 2.
      set_req(0, 64'h10, 64'h20, 1'b0, 1'b1);
      set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      set_req(3, 64'h3, 64'h4, 1'b0, 1'b1);
      req_valid = 4'b1101;
      #1;
      check("chain_w0_ready", req_ready, 4'b0100);
      step();
      check("chain_w0_sum", resp_sum, 64'h0);
      check("chain_w0_cout", resp_cout, 1'b1);
      check("chain_w0_id", resp_id, 3'd2);
      set_req(2, 64'h0, 64'h0, 1'b0, 1'b1);
      #1;
      check("chain_w1_ready", req_ready, 4'b0100);
      step();
      check("chain_w1_sum", resp_sum, 64'h1);
      check("chain_w1_cout", resp_cout, 1'b0);
      check("chain_w1_id", resp_id, 3'd2);
      check("chain_next_ready", req_ready, 4'b1000);
      step();
      req_valid = '0;
      check("chain_next_id", resp_id, 3'd3);
      check("chain_next_sum", resp_sum, 64'h7);
`endif

      // Async reset with a result in the slot (and a lock held when chaining is built).
      set_req(1, 64'h5, 64'h6, 1'b0, 1'b0);
      req_valid = 4'b0010;
      #1;
      check("ar_pre_ready", req_ready, 4'b0010);
      step();
      check("ar_pre_valid", resp_valid, 1'b1);
      check("ar_pre_sum", resp_sum, 64'hB);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", resp_valid, 1'b0);
      check("ar_sum", resp_sum, 64'h0);
      check("ar_cout", resp_cout, 1'b0);
      check("ar_id", resp_id, 3'd0);
      check("ar_ready", req_ready, 4'b0000);
      #2;
      rst_n = 1'b1;
      req_last  = '1;
      req_valid = 4'b1111;
      #1;
      check("ar_first_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      check("ar_first_id", resp_id, 3'd0);
      check("ar_first_valid", resp_valid, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
